// File: rtl/tx_frame_sequencer.sv
// Transmit frame sequencer: serialises one parallel word per request into
// start / data (LSB first) / optional parity / stop, and drives the 2-bit
// select of the downstream 4:1 line mux (A=1, B=0, C=data_bit, D=parity_bit).
module tx_frame_sequencer #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY_EN    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic              busy,
   output logic              done,
   output logic [1:0]        switch,
   output logic              data_bit,
   output logic              parity_bit
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IdxLast = IDX_W'(DATA_W - 1);
   localparam logic ParOdd = (PARITY_ODD != 0);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              parity_q, parity_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [1:0]        switch_q, switch_d;
   logic              bit_end;

   // Next-state, bit timing and registered-output decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      bit_end  = (cnt_q == CntLast);

      // Baud counter free-runs 0..CLKS_PER_BIT-1 in every non-idle state.
      if (state_q != StIdle) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               shift_d  = data_in;
               parity_d = (^data_in) ^ ParOdd;
               cnt_d    = '0;
               state_d  = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               idx_d   = '0;
               state_d = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 1'b1;
               if (idx_q == IdxLast) begin
                  state_d = (PARITY_EN != 0) ? StParity : StStop;
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               state_d = StStop;
            end
         end
         StStop: begin
            if (bit_end) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are decoded from the next state so they register in step with it.
      busy_d = (state_d != StIdle);
      done_d = (state_d == StStop) && (cnt_d == CntLast);
      case (state_d)
         StStart:  switch_d = 2'b01;
         StData:   switch_d = 2'b10;
         StParity: switch_d = 2'b11;
         default:  switch_d = 2'b00;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         switch_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         switch_q <= switch_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign switch     = switch_q;
   assign data_bit   = shift_q[0];
   assign parity_bit = parity_q;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Scoreboard bench: three sequencer instances (even parity, odd parity, no
// parity), CLKS_PER_BIT=4. Stimulus pushes per-cycle expected records; a
// negedge monitor pops one record per cycle and compares the mux line.
module tb_tx_frame_sequencer;

   localparam int CPB = 4;

   typedef struct packed {
      logic [1:0] sw;
      logic       busy;
      logic       done;
      logic       line;
   } rec_t;

   logic       clk = 1'b0;
   logic       rstb;
   logic       start_a  [3];
   logic [7:0] din_a    [3];
   logic       busy_a   [3];
   logic       done_a   [3];
   logic [1:0] sw_a     [3];
   logic       dbit_a   [3];
   logic       pbit_a   [3];

   rec_t q0[$];
   rec_t q1[$];
   rec_t q2[$];

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   tx_frame_sequencer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
      .clk(clk), .rstb(rstb), .start(start_a[0]), .data_in(din_a[0]), .busy(busy_a[0]),
      .done(done_a[0]), .switch(sw_a[0]), .data_bit(dbit_a[0]), .parity_bit(pbit_a[0]));

   tx_frame_sequencer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
      .clk(clk), .rstb(rstb), .start(start_a[1]), .data_in(din_a[1]), .busy(busy_a[1]),
      .done(done_a[1]), .switch(sw_a[1]), .data_bit(dbit_a[1]), .parity_bit(pbit_a[1]));

   tx_frame_sequencer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (
      .clk(clk), .rstb(rstb), .start(start_a[2]), .data_in(din_a[2]), .busy(busy_a[2]),
      .done(done_a[2]), .switch(sw_a[2]), .data_bit(dbit_a[2]), .parity_bit(pbit_a[2]));

   task automatic push_rec(input int id, input rec_t r);
      case (id)
         0:       q0.push_back(r);
         1:       q1.push_back(r);
         default: q2.push_back(r);
      endcase
   endtask

   // Expected per-cycle records of one whole frame, from first busy cycle to last.
   task automatic push_frame(input int id, input logic [7:0] d, input bit pen, input bit podd);
      for (int c = 0; c < CPB; c++) push_rec(id, '{sw: 2'b01, busy: 1'b1, done: 1'b0, line: 1'b0});
      for (int b = 0; b < 8; b++)
         for (int c = 0; c < CPB; c++)
            push_rec(id, '{sw: 2'b10, busy: 1'b1, done: 1'b0, line: d[b]});
      if (pen)
         for (int c = 0; c < CPB; c++)
            push_rec(id, '{sw: 2'b11, busy: 1'b1, done: 1'b0, line: (^d) ^ podd});
      for (int c = 0; c < CPB; c++)
         push_rec(id, '{sw: 2'b00, busy: 1'b1, done: (c == CPB - 1), line: 1'b1});
   endtask

   function automatic int qsize(input int id);
      case (id)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic check_cycle(input int id);
      rec_t exp_r;
      rec_t got;
      logic line;
      case (sw_a[id])
         2'b00:   line = 1'b1;
         2'b01:   line = 1'b0;
         2'b10:   line = dbit_a[id];
         default: line = pbit_a[id];
      endcase
      got = '{sw: sw_a[id], busy: busy_a[id], done: done_a[id], line: line};
      exp_r = '{sw: 2'b00, busy: 1'b0, done: 1'b0, line: 1'b1};
      if (qsize(id) > 0) begin
         case (id)
            0:       exp_r = q0.pop_front();
            1:       exp_r = q1.pop_front();
            default: exp_r = q2.pop_front();
         endcase
      end
      checks++;
      if (got !== exp_r) begin
         errors++;
         $display("FAIL dut%0d_cycle t=%0t got sw=%b busy=%b done=%b line=%b exp sw=%b busy=%b done=%b line=%b",
                  id, $time, got.sw, got.busy, got.done, got.line,
                  exp_r.sw, exp_r.busy, exp_r.done, exp_r.line);
      end
   endtask

   // Monitor: one record per instance per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         check_cycle(0);
         check_cycle(1);
         check_cycle(2);
      end
   end

   // Drive start for one edge; the accepting edge defines the frame start.
   task automatic send(input int id, input logic [7:0] d, input bit pen, input bit podd);
      start_a[id] = 1'b1;
      din_a[id]   = d;
      @(posedge clk); #1;
      push_frame(id, d, pen, podd);
      start_a[id] = 1'b0;
   endtask

   initial begin
      rstb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_a[i] = 1'b1;
         din_a[i]   = 8'hFF;
      end

      // Reset held with start high: must stay idle.
      @(posedge clk); #1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
      rstb = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Basic even-parity frame.
      send(0, 8'hA5, 1'b1, 1'b0);
      repeat (47) @(posedge clk);
      #1;

      // Odd parity on zero data, then no-parity frame.
      send(1, 8'h00, 1'b1, 1'b1);
      repeat (47) @(posedge clk);
      #1;
      send(2, 8'hFF, 1'b0, 1'b0);
      repeat (43) @(posedge clk);
      #1;

      // Start and data changes mid-frame are ignored.
      send(0, 8'hA5, 1'b1, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      start_a[0] = 1'b1;
      din_a[0]   = 8'h3C;
      @(posedge clk); #1;
      start_a[0] = 1'b0;
      din_a[0]   = 8'hFF;
      repeat (40) @(posedge clk);
      #1;
      din_a[0] = 8'h00;

      // Start held high: two frames with one idle cycle between them.
      start_a[0] = 1'b1;
      din_a[0]   = 8'h55;
      @(posedge clk); #1;
      push_frame(0, 8'h55, 1'b1, 1'b0);
      push_rec(0, '{sw: 2'b00, busy: 1'b0, done: 1'b0, line: 1'b1});
      push_frame(0, 8'h55, 1'b1, 1'b0);
      repeat (50) @(posedge clk);
      #1;
      start_a[0] = 1'b0;
      repeat (45) @(posedge clk);
      #1;

      // Reset during DATA bit 3, then a clean frame.
      send(0, 8'hC3, 1'b1, 1'b0);
      repeat (17) @(posedge clk);
      #1;
      rstb = 1'b0;
      @(posedge clk); #1;
      q0.delete();
      rstb = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send(0, 8'h96, 1'b1, 1'b0);
      repeat (47) @(posedge clk);
      #1;

      // Every expected record must have been consumed.
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (qsize(i) != 0) begin
            errors++;
            $display("FAIL dut%0d_drain left=%0d required=0", i, qsize(i));
         end
      end

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout got=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
